// File: rtl/d_fifo_drain.sv
// Output drain stage for the D0/D1 destination FIFOs: round-robin pops, one word in
// flight, valid/ready output tagged with source, per-source counters and sticky error.
module d_fifo_drain #(
  parameter int BW = 6,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          D0_empty,
  input  logic          D1_empty,
  input  logic          D0_error_output,
  input  logic          D1_error_output,
  input  logic [BW-1:0] D0_data_out,
  input  logic [BW-1:0] D1_data_out,
  output logic          D0_rd,
  output logic          D1_rd,
  output logic [BW-1:0] data_out,
  output logic          valid_out,
  input  logic          out_ready,
  output logic          src_out,
  output logic [CW-1:0] count0,
  output logic [CW-1:0] count1,
  output logic          error_seen
);

  typedef enum logic [1:0] {IDLE, POP, WAIT, OUT} state_t;

  state_t state, state_next;
  logic   sel, sel_next;
  logic   rr_ptr;
  logic   elig0, elig1, any_elig;
  logic   accept;

  // When both sources are eligible the pointer decides; otherwise the lone
  // eligible source wins (the none-eligible result is never used).
  function automatic logic pick(input logic ptr, input logic e0, input logic e1);
    if (e0 && e1) return ptr;
    return e1;
  endfunction

  assign elig0    = enable & ~D0_empty & ~D0_error_output;
  assign elig1    = enable & ~D1_empty & ~D1_error_output;
  assign any_elig = elig0 | elig1;
  assign accept   = (state == OUT) && out_ready;

  always_comb begin
    state_next = state;
    sel_next   = sel;
    D0_rd      = 1'b0;
    D1_rd      = 1'b0;
    case (state)
      IDLE: begin
        if (any_elig) begin
          sel_next   = pick(rr_ptr, elig0, elig1);
          state_next = POP;
        end
      end
      POP: begin
        D0_rd      = ~sel;
        D1_rd      = sel;
        state_next = WAIT;
      end
      WAIT: state_next = OUT;
      OUT: begin
        // The pointer flips to ~sel on acceptance, so reselect against that value.
        if (out_ready) begin
          if (any_elig) begin
            sel_next   = pick(~sel, elig0, elig1);
            state_next = POP;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      sel   <= 1'b0;
    end else begin
      state <= state_next;
      sel   <= sel_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out  <= '0;
      src_out   <= 1'b0;
      valid_out <= 1'b0;
      rr_ptr    <= 1'b0;
      count0    <= '0;
      count1    <= '0;
    end else begin
      if (state == WAIT) begin
        data_out  <= sel ? D1_data_out : D0_data_out;
        src_out   <= sel;
        valid_out <= 1'b1;
      end
      if (accept) begin
        valid_out <= 1'b0;
        rr_ptr    <= ~sel;
        if (sel) count1 <= count1 + CW'(1);
        else     count0 <= count0 + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) error_seen <= 1'b0;
    else if (D0_error_output || D1_error_output) error_seen <= 1'b1;
  end

endmodule

// File: tb/tb_d_fifo_drain.sv
// Directed bench for d_fifo_drain: behavioural D0/D1 FIFOs feed the DUT and a
// scoreboard queue holds the words expected at the output port, in order.
module tb_d_fifo_drain;
  localparam int BW = 6;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          D0_error_output = 1'b0;
  logic          D1_error_output = 1'b0;
  logic          out_ready = 1'b0;
  logic          D0_empty, D1_empty, D0_rd, D1_rd;
  logic          valid_out, src_out, error_seen;
  logic [BW-1:0] D0_data_out = '0;
  logic [BW-1:0] D1_data_out = '0;
  logic [BW-1:0] data_out;
  logic [CW-1:0] count0, count1;

  typedef struct packed {
    logic          src;
    logic [BW-1:0] data;
  } word_t;

  logic [BW-1:0] mem0 [512];
  logic [BW-1:0] mem1 [512];
  int    push0 = 0, push1 = 0, pop0 = 0, pop1 = 0;
  logic  bad_pop = 1'b0, both_rd = 1'b0;
  word_t exp_q[$];
  int    checks = 0, errors = 0, exp_cnt0 = 0, exp_cnt1 = 0;

  d_fifo_drain #(.BW(BW), .CW(CW)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .D0_empty(D0_empty), .D1_empty(D1_empty),
    .D0_error_output(D0_error_output), .D1_error_output(D1_error_output),
    .D0_data_out(D0_data_out), .D1_data_out(D1_data_out),
    .D0_rd(D0_rd), .D1_rd(D1_rd), .data_out(data_out), .valid_out(valid_out),
    .out_ready(out_ready), .src_out(src_out), .count0(count0), .count1(count1),
    .error_seen(error_seen)
  );

  always #5 clk = ~clk;

  // FIFO models: read data appears the cycle after the pop strobe.
  assign D0_empty = (push0 == pop0);
  assign D1_empty = (push1 == pop1);

  always @(posedge clk) begin
    if (D0_rd) begin
      if (push0 == pop0) bad_pop <= 1'b1;
      else begin
        D0_data_out <= mem0[pop0[8:0]];
        pop0 <= pop0 + 1;
      end
    end
    if (D1_rd) begin
      if (push1 == pop1) bad_pop <= 1'b1;
      else begin
        D1_data_out <= mem1[pop1[8:0]];
        pop1 <= pop1 + 1;
      end
    end
    if (D0_rd && D1_rd) both_rd <= 1'b1;
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic apply_stimulus(input logic src, input logic [BW-1:0] data, input logic expect_out);
    word_t w;
    if (src) begin
      mem1[push1[8:0]] = data;
      push1++;
    end else begin
      mem0[push0[8:0]] = data;
      push0++;
    end
    if (expect_out) begin
      w.src  = src;
      w.data = data;
      exp_q.push_back(w);
    end
  endtask

  // One clock: handshakes are judged just before the edge, then return #1 after it.
  task automatic tick();
    word_t e;
    @(negedge clk);
    if (valid_out && out_ready && !reset) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_word: observed 0x%0h src %0d expected no word", data_out, src_out);
      end else begin
        e = exp_q.pop_front();
        check_output("word_src", 32'(src_out), 32'(e.src));
        check_output("word_data", 32'(data_out), 32'(e.data));
        if (e.src) exp_cnt1++;
        else exp_cnt0++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL %s_timeout: observed %0d words pending expected 0", tag, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_cnt0 = 0;
    exp_cnt1 = 0;
  endtask

  initial begin
    int first, second, n, p0, p1;
    logic [BW-1:0] held;
    logic [CW-1:0] c0;

    $display("[TB] reset state");
    tick();
    check_output("rst_valid", 32'(valid_out), 32'd0);
    check_output("rst_data", 32'(data_out), 32'd0);
    check_output("rst_src", 32'(src_out), 32'd0);
    check_output("rst_count0", 32'(count0), 32'd0);
    check_output("rst_count1", 32'(count1), 32'd0);
    check_output("rst_error", 32'(error_seen), 32'd0);
    check_output("rst_rd", 32'({D0_rd, D1_rd}), 32'd0);
    reset = 1'b0;
    enable = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_output("idle_no_rd", 32'({D0_rd, D1_rd}), 32'd0);
    end

    $display("[TB] two words from D0");
    apply_stimulus(1'b0, 6'h11, 1'b1);
    apply_stimulus(1'b0, 6'h1F, 1'b1);
    first = -1;
    second = -1;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      tick();
      n++;
      if (D0_rd) begin
        if (first < 0) first = n;
        else second = n;
      end
    end
    check_output("d0_pending", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    check_output("d0_first_rd_cycle", 32'(first), 32'd1);
    check_output("d0_rd_spacing", 32'(second - first), 32'd3);
    check_output("d0_count0", 32'(count0), 32'(exp_cnt0 & 255));
    check_output("d0_count0_abs", 32'(count0), 32'd2);
    check_output("d0_no_d1_pop", 32'(pop1), 32'd0);

    $display("[TB] both FIFOs hold three words");
    pulse_reset();
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b0, 6'(8'h20 + i), 1'b1);
      apply_stimulus(1'b1, 6'(8'h30 + i), 1'b1);
    end
    drain("rr", 40);
    check_output("rr_count0", 32'(count0), 32'd3);
    check_output("rr_count1", 32'(count1), 32'd3);

    $display("[TB] back-pressure");
    out_ready = 1'b0;
    apply_stimulus(1'b0, 6'h2A, 1'b1);
    apply_stimulus(1'b0, 6'h15, 1'b1);
    n = 0;
    while (!valid_out && n < 20) begin
      tick();
      n++;
    end
    check_output("bp_valid_seen", 32'(valid_out), 32'd1);
    held = data_out;
    c0 = count0;
    p0 = pop0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_output("bp_data_hold", 32'(data_out), 32'(held));
      check_output("bp_valid_hold", 32'(valid_out), 32'd1);
      check_output("bp_no_rd", 32'({D0_rd, D1_rd}), 32'd0);
      check_output("bp_count_hold", 32'(count0), 32'(c0));
    end
    check_output("bp_no_pop", 32'(pop0), 32'(p0));
    out_ready = 1'b1;
    tick();
    check_output("bp_pop_same_edge", 32'(D0_rd), 32'd1);
    drain("bp", 20);
    check_output("bp_count0", 32'(count0), 32'(exp_cnt0 & 255));

    $display("[TB] D1 error excludes D1");
    D1_error_output = 1'b1;
    p1 = pop1;
    apply_stimulus(1'b0, 6'h05, 1'b1);
    apply_stimulus(1'b0, 6'h06, 1'b1);
    apply_stimulus(1'b1, 6'h07, 1'b0);
    apply_stimulus(1'b1, 6'h08, 1'b0);
    drain("err", 30);
    for (int i = 0; i < 4; i++) tick();
    check_output("err_no_d1_pop", 32'(pop1), 32'(p1));
    check_output("err_sticky_set", 32'(error_seen), 32'd1);
    check_output("err_idle", 32'(valid_out), 32'd0);
    apply_stimulus(1'b1, 6'h07, 1'b1);
    exp_q.pop_back();
    exp_q.push_back('{src: 1'b1, data: 6'h07});
    exp_q.push_back('{src: 1'b1, data: 6'h08});
    push1 = push1 - 1;
    D1_error_output = 1'b0;
    drain("err_clear", 30);
    check_output("err_sticky_hold", 32'(error_seen), 32'd1);
    check_output("err_count1", 32'(count1), 32'(exp_cnt1 & 255));

    $display("[TB] reset during WAIT");
    pulse_reset();
    check_output("rst2_error_clear", 32'(error_seen), 32'd0);
    apply_stimulus(1'b0, 6'h3C, 1'b0);
    n = 0;
    while (!D0_rd && n < 10) begin
      tick();
      n++;
    end
    check_output("rst2_rd_seen", 32'(D0_rd), 32'd1);
    tick();
    reset = 1'b1;
    #1;
    check_output("rst2_valid_async", 32'(valid_out), 32'd0);
    check_output("rst2_rd_async", 32'({D0_rd, D1_rd}), 32'd0);
    tick();
    reset = 1'b0;
    exp_cnt0 = 0;
    exp_cnt1 = 0;
    p0 = pop0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_output("rst2_valid_low", 32'(valid_out), 32'd0);
      check_output("rst2_no_rd", 32'({D0_rd, D1_rd}), 32'd0);
    end
    check_output("rst2_count0", 32'(count0), 32'd0);
    check_output("rst2_no_pop", 32'(pop0), 32'(p0));
    apply_stimulus(1'b0, 6'h0E, 1'b1);
    drain("rst2_recover", 20);

    $display("[TB] counter wrap");
    pulse_reset();
    for (int i = 0; i < 258; i++) apply_stimulus(1'b0, 6'(i), 1'b1);
    drain("wrap", 258 * 3 + 30);
    check_output("wrap_count0", 32'(count0), 32'(exp_cnt0 & 255));
    check_output("wrap_count0_abs", 32'(count0), 32'd2);
    check_output("wrap_count1", 32'(count1), 32'd0);

    check_output("never_empty_pop", 32'(bad_pop), 32'd0);
    check_output("never_both_rd", 32'(both_rd), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
